// File: rtl/step_scan_pkg.sv
// step_scan_pkg: debounce state encoding, default constants and width helper for step_scan_ctrl
package step_scan_pkg;
  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } db_state_e;
  localparam int DEF_DB_CYCLES = 1000000;
  localparam int DEF_SCAN_DIV  = 100000;
  localparam int DEF_NUM_STEPS = 10;
  localparam int IDX_W         = 4;
  // counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser plus four-state debounce FSM for one push-button
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   raw    : raw button level, asynchronous to clk
//   stable : debounced level (S_HIGH or S_WAIT_LOW)
//   rise   : one-cycle pulse on a qualified press
module btn_debounce
  import step_scan_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise
);
  localparam int CW = cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] TC = CW'(DB_CYCLES - 1);
  logic [1:0] sync;
  logic s;
  db_state_e state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic rise_nx;
  assign s = sync[1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b00;
      state <= S_LOW;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      state <= state_nx;
      cnt   <= cnt_nx;
      rise  <= rise_nx;
    end
  end
  // rise is only raised on the WAIT_HIGH -> HIGH transition; a bounce back
  // from WAIT_LOW is the same press and stays silent
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rise_nx  = 1'b0;
    case (state)
      S_LOW:
        if (s) begin
          state_nx = S_WAIT_HIGH;
          cnt_nx   = '0;
        end
      S_WAIT_HIGH:
        if (!s) state_nx = S_LOW;
        else if (cnt == TC) begin
          state_nx = S_HIGH;
          rise_nx  = 1'b1;
        end else cnt_nx = cnt + 1'b1;
      S_HIGH:
        if (!s) begin
          state_nx = S_WAIT_LOW;
          cnt_nx   = '0;
        end
      S_WAIT_LOW:
        if (s) state_nx = S_HIGH;
        else if (cnt == TC) state_nx = S_LOW;
        else cnt_nx = cnt + 1'b1;
      default: state_nx = S_LOW;
    endcase
  end
  assign stable = (state == S_HIGH) || (state == S_WAIT_LOW);
endmodule

// File: rtl/step_scan_ctrl.sv
// step_scan_ctrl: front-panel control - debounced single-step, instruction index and display scan clock
//   CLK          : system clock
//   RST_n        : asynchronous active-low reset
//   btn_step_raw : raw single-step button
//   btn_show_raw : raw result/operand select button
//   step_pulse   : one-cycle pulse per accepted step press
//   i            : instruction index 0..NUM_STEPS-1
//   button_up    : debounced show level (1 = result, 0 = operand)
//   scan_clk     : 50% duty clock, period SCAN_DIV cycles
module step_scan_ctrl
  import step_scan_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int SCAN_DIV  = DEF_SCAN_DIV,
  parameter int NUM_STEPS = DEF_NUM_STEPS
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             btn_step_raw,
  input  logic             btn_show_raw,
  output logic             step_pulse,
  output logic [IDX_W-1:0] i,
  output logic             button_up,
  output logic             scan_clk
);
  localparam int SW = cnt_w(SCAN_DIV / 2);
  localparam logic [SW-1:0] SCAN_TC = SW'(SCAN_DIV / 2 - 1);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(NUM_STEPS - 1);
  logic unused_step_stable;
  logic unused_show_rise;
  logic [SW-1:0] scnt;
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step (
    .clk    (CLK),
    .rst_n  (RST_n),
    .raw    (btn_step_raw),
    .stable (unused_step_stable),
    .rise   (step_pulse)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_show (
    .clk    (CLK),
    .rst_n  (RST_n),
    .raw    (btn_show_raw),
    .stable (button_up),
    .rise   (unused_show_rise)
  );
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) i <= '0;
    else if (step_pulse) i <= (i == I_LAST) ? '0 : i + 1'b1;
  end
  // half-period counter; scan_clk flips at each terminal count
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      scnt     <= '0;
      scan_clk <= 1'b0;
    end else if (scnt == SCAN_TC) begin
      scnt     <= '0;
      scan_clk <= ~scan_clk;
    end else scnt <= scnt + 1'b1;
  end
endmodule

// File: tb/tb_step_scan_ctrl.sv
// tb_step_scan_ctrl: scoreboard bench for step_scan_ctrl with small debounce/scan constants
module tb_step_scan_ctrl;
  localparam int DB = 4;
  localparam int SD = 4;
  localparam int NS = 10;
  typedef struct {
    int cyc;
    int idx;
  } exp_t;
  logic CLK, RST_n, btn_step_raw, btn_show_raw;
  logic step_pulse, button_up, scan_clk;
  logic [3:0] i;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int exp_i = 0;
  int i_exp = 0;
  logic i_pend = 1'b0;
  exp_t q[$];
  step_scan_ctrl #(.DB_CYCLES(DB), .SCAN_DIV(SD), .NUM_STEPS(NS)) dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .btn_step_raw (btn_step_raw),
    .btn_show_raw (btn_show_raw),
    .step_pulse   (step_pulse),
    .i            (i),
    .button_up    (button_up),
    .scan_clk     (scan_clk)
  );
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  // scoreboard: every observed pulse must match the oldest expected pulse
  always @(negedge CLK) begin
    if (i_pend) begin
      check("i_after_pulse", i, i_exp);
      i_pend = 1'b0;
    end
    if (step_pulse) begin
      if (q.size() == 0) check("spurious_pulse", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        i_exp = e.idx;
        i_pend = 1'b1;
      end
    end
  end
  task automatic expect_step();
    exp_i = (exp_i + 1) % NS;
    q.push_back('{cyc: cyc + DB + 3, idx: exp_i});
  endtask
  task automatic press(input int hold, input logic push);
    @(negedge CLK);
    btn_step_raw = 1'b1;
    if (push) expect_step();
    repeat (hold) @(negedge CLK);
    btn_step_raw = 1'b0;
    repeat (DB + 6) @(negedge CLK);
  endtask
  task automatic check_reset_outs(input string tag);
    check({tag, "_pulse"}, step_pulse, 0);
    check({tag, "_i"}, i, 0);
    check({tag, "_bu"}, button_up, 0);
    check({tag, "_scan"}, scan_clk, 0);
  endtask
  initial begin
    RST_n = 1'b0;
    btn_step_raw = 1'b0;
    btn_show_raw = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outs("por");
    @(negedge CLK);
    RST_n = 1'b1;
    rel_cyc = cyc;
    @(posedge CLK); #1 check("scan_first_lo", scan_clk, 0);
    @(posedge CLK); #1 check("scan_first_hi", scan_clk, 1);
    press(20, 1'b1);
    press(3, 1'b0);
    check("glitch_i", i, exp_i);
    @(negedge CLK);
    btn_step_raw = 1'b1;
    expect_step();
    repeat (10) @(negedge CLK);
    btn_step_raw = 1'b0;
    @(negedge CLK);
    btn_step_raw = 1'b1;
    repeat (10) @(negedge CLK);
    btn_step_raw = 1'b0;
    repeat (DB + 6) @(negedge CLK);
    for (int k = 0; k < 10; k++) press(8, 1'b1);
    check("wrap_i", i, 2);
    @(negedge CLK);
    btn_show_raw = 1'b1;
    btn_step_raw = 1'b1;
    expect_step();
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (k == 6) check("bu_rise_early", button_up, 0);
      if (k == 7) check("bu_rise", button_up, 1);
    end
    btn_show_raw = 1'b0;
    btn_step_raw = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (k == 6) check("bu_fall_early", button_up, 1);
      if (k == 7) check("bu_fall", button_up, 0);
    end
    press(8, 1'b1);
    press(8, 1'b1);
    check("pre_reset_i", i, 5);
    @(negedge CLK);
    btn_step_raw = 1'b1;
    repeat (4) @(negedge CLK);
    @(posedge CLK);
    #2 RST_n = 1'b0;
    #1 check_reset_outs("async_rst");
    q.delete();
    exp_i = 0;
    @(negedge CLK);
    check_reset_outs("held_rst");
    RST_n = 1'b1;
    rel_cyc = cyc;
    expect_step();
    @(posedge CLK); #1 check("scan_rel_lo", scan_clk, 0);
    @(posedge CLK); #1 check("scan_rel_hi", scan_clk, 1);
    repeat (12) @(negedge CLK);
    btn_step_raw = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      check("scan_phase", scan_clk, ((cyc - rel_cyc) / 2) % 2);
    end
    repeat (10) @(negedge CLK);
    check("sb_empty", q.size(), 0);
    check("i_final", i, exp_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
